vga_apb_arbiter: RTL and testbench
==================================

VGA_APB_ARBITER -- requirements
Module: vga_apb_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, giving the maximum number of ACCESS cycles to wait for out_pready before forcing an error completion (minimum 2).
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have ports m0_paddr/m0_pwdata (input, 32 each), m0_psel/m0_penable/m0_pwrite (input, 1 each), m0_pprot (input, 3) and m0_pstrb (input, 4): APB requester 0 (CPU).
REQ-005 The block SHALL have ports m0_pready/m0_pslverr (output, 1 each) and m0_prdata (output, 32): APB requester 0 response.
REQ-006 The block SHALL provide the same port set with prefix m1_ for APB requester 1 (DMA/blitter).
REQ-007 The block SHALL have ports out_paddr/out_pwdata (output, 32 each), out_psel/out_penable/out_pwrite (output, 1 each), out_pprot (output, 3) and out_pstrb (output, 4): the shared APB bus to the VGA frame-buffer slave.
REQ-008 The block SHALL have ports out_pready/out_pslverr (input, 1 each) and out_prdata (input, 32): the slave response.

Function
REQ-009 The block SHALL implement three states: IDLE (no grant), SETUP (out_psel=1, out_penable=0, one cycle) and ACCESS (out_psel=1, out_penable=1).
REQ-010 A requester SHALL be pending when its mN_psel=1, in either its setup or its access phase.
REQ-011 In IDLE, if any requester is pending, the block SHALL latch the grant (gnt) and move to SETUP on the next edge; otherwise it stays in IDLE.
REQ-012 Arbitration SHALL be round-robin: when both are pending, grant the requester not served last. The last-served pointer updates only on completion.
REQ-013 In SETUP and ACCESS, out_paddr, out_pwrite, out_pwdata, out_pstrb and out_pprot SHALL combinationally follow the granted requester's inputs; in IDLE they SHALL be 0.
REQ-014 SETUP SHALL last exactly one cycle, then go to ACCESS.
REQ-015 In ACCESS, completion SHALL occur in a cycle with out_pready=1 or the timeout condition; the block then returns to IDLE on the next edge.
REQ-016 On a completion cycle, the block SHALL drive, combinationally and for that cycle only: mG_pready=1, mG_prdata=out_prdata and mG_pslverr=out_pslverr for the granted requester G.
REQ-017 Timeout: a counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without out_pready.
REQ-018 Timeout SHALL fire when that counter equals TIMEOUT-1 and out_pready=0; the completion then gives mG_pslverr=1 and mG_prdata=0.
REQ-019 out_pready=1 in the same cycle as the timeout condition SHALL take priority, giving a normal completion.
REQ-020 The non-granted requester SHALL see pready=0, pslverr=0, prdata=0 at all times; its request SHALL wait with no loss.
REQ-021 If the granted requester drops psel before completion (protocol violation), the block SHALL still finish the slave transfer and discard the response.
REQ-022 Minimum latency SHALL be 3 cycles from request pending in IDLE to mN_pready (IDLE, SETUP, ACCESS with out_pready=1 immediately); back-to-back grants SHALL insert one IDLE cycle.
REQ-023 out_pslverr SHALL be passed through unmodified on a normal completion.

Reset
REQ-024 Asserting reset SHALL, asynchronously: set the state to IDLE, clear gnt and the timeout counter, and set the last-served pointer to 1 so m0 wins the first tie.
REQ-025 While reset is asserted, all out_* and mN_* outputs SHALL be 0.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer with no pready pulse to any requester.
REQ-027 After reset deasserts, arbitration SHALL start on the first rising edge.

Verification
REQ-028 m0 write addr 0x0000_0010, data 0x00FF_0000, slave pready in the first ACCESS cycle -> out_psel high for cycles 2-3, out_penable only in cycle 3, m0_pready=1 in cycle 3.
REQ-029 m0 and m1 both request from reset -> m0 granted first, then m1 after one IDLE cycle; a repeat with both pending again -> m0 is granted again (alternation holds).
REQ-030 Slave never asserts pready, TIMEOUT=16 -> exactly 16 ACCESS cycles, then mG_pready=1, pslverr=1, prdata=0, and the state returns to IDLE.
REQ-031 Slave asserts pready with pslverr=1 in the 4th ACCESS cycle -> mG_pslverr=1 in that cycle; the other requester sees no response.
REQ-032 Reset pulsed during ACCESS of an m1 transfer -> all outputs 0 immediately and no m1_pready; after release with both pending, m0 is granted first.

Source files
------------

// File: rtl/vga_apb_arbiter.sv
// Two-requester APB arbiter in front of the VGA frame-buffer slave.
// Round-robin grant, one IDLE cycle between transfers, ACCESS timeout with forced error.
module vga_apb_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset,
   // requester 0 (CPU)
   input  logic [31:0] m0_paddr,
   input  logic [31:0] m0_pwdata,
   input  logic        m0_psel,
   input  logic        m0_penable,
   input  logic        m0_pwrite,
   input  logic [2:0]  m0_pprot,
   input  logic [3:0]  m0_pstrb,
   output logic        m0_pready,
   output logic        m0_pslverr,
   output logic [31:0] m0_prdata,
   // requester 1 (DMA/blitter)
   input  logic [31:0] m1_paddr,
   input  logic [31:0] m1_pwdata,
   input  logic        m1_psel,
   input  logic        m1_penable,
   input  logic        m1_pwrite,
   input  logic [2:0]  m1_pprot,
   input  logic [3:0]  m1_pstrb,
   output logic        m1_pready,
   output logic        m1_pslverr,
   output logic [31:0] m1_prdata,
   // shared bus to the slave
   output logic [31:0] out_paddr,
   output logic [31:0] out_pwdata,
   output logic        out_psel,
   output logic        out_penable,
   output logic        out_pwrite,
   output logic [2:0]  out_pprot,
   output logic [3:0]  out_pstrb,
   input  logic        out_pready,
   input  logic        out_pslverr,
   input  logic [31:0] out_prdata
);

   localparam int unsigned CntW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_t;

   state_t            state_q, state_d;
   logic              gnt_q, gnt_d;
   logic              last_q, last_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              timeout;
   logic              complete;
   logic              unused_penable;

   // Pending is decided by psel alone, so requester penable carries no information here.
   assign unused_penable = m0_penable ^ m1_penable;

   assign timeout  = (state_q == StAccess) && (cnt_q == CntW'(TIMEOUT - 1)) && !out_pready;
   assign complete = (state_q == StAccess) && (out_pready || (cnt_q == CntW'(TIMEOUT - 1)));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (m0_psel || m1_psel) begin
               state_d = StSetup;
               gnt_d   = (m0_psel && m1_psel) ? ~last_q : m1_psel;
            end
         end
         StSetup: begin
            state_d = StAccess;
            cnt_d   = '0;
         end
         StAccess: begin
            if (complete) begin
               state_d = StIdle;
               last_d  = gnt_q;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      out_psel    = 1'b0;
      out_penable = 1'b0;
      out_paddr   = '0;
      out_pwdata  = '0;
      out_pwrite  = 1'b0;
      out_pprot   = '0;
      out_pstrb   = '0;
      m0_pready   = 1'b0;
      m0_pslverr  = 1'b0;
      m0_prdata   = '0;
      m1_pready   = 1'b0;
      m1_pslverr  = 1'b0;
      m1_prdata   = '0;
      if (state_q != StIdle) begin
         out_psel    = 1'b1;
         out_penable = (state_q == StAccess);
         if (gnt_q) begin
            out_paddr  = m1_paddr;
            out_pwdata = m1_pwdata;
            out_pwrite = m1_pwrite;
            out_pprot  = m1_pprot;
            out_pstrb  = m1_pstrb;
         end else begin
            out_paddr  = m0_paddr;
            out_pwdata = m0_pwdata;
            out_pwrite = m0_pwrite;
            out_pprot  = m0_pprot;
            out_pstrb  = m0_pstrb;
         end
      end
      // A requester that abandoned its transfer gets no response.
      if (complete) begin
         if (gnt_q && m1_psel) begin
            m1_pready  = 1'b1;
            m1_pslverr = timeout | out_pslverr;
            m1_prdata  = timeout ? '0 : out_prdata;
         end else if (!gnt_q && m0_psel) begin
            m0_pready  = 1'b1;
            m0_pslverr = timeout | out_pslverr;
            m0_prdata  = timeout ? '0 : out_prdata;
         end
      end
   end

endmodule

// File: tb/tb_vga_apb_arbiter.sv
// Self-checking bench for vga_apb_arbiter: directed table, corner sequences, random vs model.
module tb_vga_apb_arbiter;

   localparam int TO = 16;
   localparam logic [31:0] A0 = 32'h0000_0010, WD0 = 32'h00FF_0000;
   localparam logic [31:0] A1 = 32'h0000_2000, WD1 = 32'hAAAA_5555;
   localparam logic [31:0] PRD = 32'h1234_5678;

   logic clock, reset;
   logic [31:0] m0_paddr, m0_pwdata, m0_prdata, m1_paddr, m1_pwdata, m1_prdata;
   logic m0_psel, m0_penable, m0_pwrite, m0_pready, m0_pslverr;
   logic m1_psel, m1_penable, m1_pwrite, m1_pready, m1_pslverr;
   logic [2:0] m0_pprot, m1_pprot, out_pprot;
   logic [3:0] m0_pstrb, m1_pstrb, out_pstrb;
   logic [31:0] out_paddr, out_pwdata, out_prdata;
   logic out_psel, out_penable, out_pwrite, out_pready, out_pslverr;

   vga_apb_arbiter #(.TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_psel(m0_psel), .m0_penable(m0_penable),
      .m0_pwrite(m0_pwrite), .m0_pprot(m0_pprot), .m0_pstrb(m0_pstrb), .m0_pready(m0_pready),
      .m0_pslverr(m0_pslverr), .m0_prdata(m0_prdata),
      .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_psel(m1_psel), .m1_penable(m1_penable),
      .m1_pwrite(m1_pwrite), .m1_pprot(m1_pprot), .m1_pstrb(m1_pstrb), .m1_pready(m1_pready),
      .m1_pslverr(m1_pslverr), .m1_prdata(m1_prdata),
      .out_paddr(out_paddr), .out_pwdata(out_pwdata), .out_psel(out_psel),
      .out_penable(out_penable), .out_pwrite(out_pwrite), .out_pprot(out_pprot),
      .out_pstrb(out_pstrb), .out_pready(out_pready), .out_pslverr(out_pslverr),
      .out_prdata(out_prdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [159:0] dut_vec();
      return {18'd0, out_psel, out_penable, out_paddr, out_pwrite, out_pwdata, out_pstrb,
              out_pprot, m0_pready, m0_pslverr, m0_prdata, m1_pready, m1_pslverr, m1_prdata};
   endfunction

   // Reference model: a transfer is either absent or at a given age (0 = setup cycle).
   bit m_act, m_own, m_last, m_done;
   int m_age;

   function automatic logic [159:0] model_out(output bit done);
      logic sel, en, wr, r0, r1, e0, e1, own_sel, err;
      logic [31:0] addr, wd, d0, d1, rd;
      logic [3:0] st;
      logic [2:0] pr;
      {sel, en, wr, r0, r1, e0, e1, own_sel, err} = '0;
      {addr, wd, d0, d1, rd, st, pr} = '0;
      done = 1'b0;
      if (m_act) begin
         sel = 1'b1;
         en  = (m_age > 0);
         if (m_own) begin
            addr = m1_paddr; wd = m1_pwdata; wr = m1_pwrite; st = m1_pstrb; pr = m1_pprot;
            own_sel = m1_psel;
         end else begin
            addr = m0_paddr; wd = m0_pwdata; wr = m0_pwrite; st = m0_pstrb; pr = m0_pprot;
            own_sel = m0_psel;
         end
         if (en) begin
            done = out_pready || (m_age == TO);
            err  = out_pready ? out_pslverr : 1'b1;
            rd   = out_pready ? out_prdata : 32'h0;
            if (done && own_sel) begin
               if (m_own) begin r1 = 1'b1; e1 = err; d1 = rd; end
               else begin r0 = 1'b1; e0 = err; d0 = rd; end
            end
         end
      end
      return {18'd0, sel, en, addr, wr, wd, st, pr, r0, e0, d0, r1, e1, d1};
   endfunction

   task automatic model_step();
      if (!m_act) begin
         if (m0_psel || m1_psel) begin
            m_act = 1'b1;
            m_age = 0;
            m_own = (m0_psel && m1_psel) ? !m_last : m1_psel;
         end
      end else if (m_done) begin
         m_act  = 1'b0;
         m_last = m_own;
      end else begin
         m_age++;
      end
   endtask

   typedef struct {
      logic m0s, m1s, rdy, err;
      logic psel, pen;
      logic [31:0] addr;
      logic r0, r1, e0, e1;
   } vec_t;

   vec_t tbl[17];

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [159:0] exp;
      logic [31:0] wd;
      logic wr;
      logic [3:0] st;
      logic [2:0] pr;
      bit done, saw0, saw1;
      int n, rate;

      tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, A0,    1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, A0,    1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, A1,    1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, A1,    1'b0, 1'b1, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, A0,    1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, A0,    1'b1, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, A1,    1'b0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, A1,    1'b0, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, A1,    1'b0, 1'b1, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, A0,    1'b0, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, A0,    1'b0, 1'b0, 1'b0, 1'b0};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};

      reset = 1'b1;
      m0_paddr = A0; m0_pwdata = WD0; m0_pwrite = 1'b1; m0_pstrb = 4'hF; m0_pprot = 3'b001;
      m1_paddr = A1; m1_pwdata = WD1; m1_pwrite = 1'b0; m1_pstrb = 4'h3; m1_pprot = 3'b010;
      m0_psel = 1'b1; m1_psel = 1'b1; m0_penable = 1'b0; m1_penable = 1'b0;
      out_pready = 1'b1; out_pslverr = 1'b1; out_prdata = PRD;

      @(negedge clock);
      check("reset_outputs", dut_vec(), 160'd0);
      next_cycle();
      reset = 1'b0;

      // Directed table: first grant, alternation, pslverr passthrough, abandoned transfer.
      for (int i = 0; i < 17; i++) begin
         m0_psel = tbl[i].m0s; m1_psel = tbl[i].m1s;
         out_pready = tbl[i].rdy; out_pslverr = tbl[i].err;
         {wd, wr, st, pr} = '0;
         if (tbl[i].addr == A0) begin wd = WD0; wr = 1'b1; st = 4'hF; pr = 3'b001; end
         if (tbl[i].addr == A1) begin wd = WD1; wr = 1'b0; st = 4'h3; pr = 3'b010; end
         exp = {18'd0, tbl[i].psel, tbl[i].pen, tbl[i].addr, wr, wd, st, pr,
                tbl[i].r0, tbl[i].e0, tbl[i].r0 ? PRD : 32'h0,
                tbl[i].r1, tbl[i].e1, tbl[i].r1 ? PRD : 32'h0};
         @(negedge clock);
         check($sformatf("table_row%0d", i), dut_vec(), exp);
         next_cycle();
      end

      // Timeout: slave never ready.
      m0_psel = 1'b0; m1_psel = 1'b1; out_pready = 1'b0; out_pslverr = 1'b0;
      out_prdata = 32'hDEAD_BEEF;
      @(negedge clock);
      check("to_idle", 160'(out_psel), 160'd0);
      next_cycle();
      @(negedge clock);
      check("to_setup", 160'({out_psel, out_penable, out_paddr}), 160'({2'b10, A1}));
      next_cycle();
      n = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clock);
         if (out_penable) n++;
         if (m1_pready) begin
            done = 1'b1;
            check("to_response", 160'({m1_pslverr, m1_prdata, m0_pready, m0_pslverr, m0_prdata}),
                  160'({1'b1, 32'h0, 1'b0, 1'b0, 32'h0}));
         end
         next_cycle();
         if (done) m1_psel = 1'b0;
      end
      check("to_completed", 160'(done), 160'd1);
      check("to_access_cycles", 160'(n), 160'(TO));
      @(negedge clock);
      check("to_back_idle", 160'(out_psel), 160'd0);
      next_cycle();

      // Slave error on 4th ACCESS cycle while m1 waits.
      m0_psel = 1'b1; m1_psel = 1'b1; out_prdata = 32'h5A5A_0001;
      next_cycle();
      @(negedge clock);
      check("err_setup_m0", 160'({out_psel, out_penable, out_paddr}), 160'({2'b10, A0}));
      next_cycle();
      for (int k = 0; k < 4; k++) begin
         out_pready = (k == 3); out_pslverr = (k == 3);
         @(negedge clock);
         if (k == 3)
            check("err_4th_access",
                  160'({m0_pready, m0_pslverr, m0_prdata, m1_pready, m1_pslverr, m1_prdata}),
                  160'({2'b11, 32'h5A5A_0001, 2'b00, 32'h0}));
         else
            check($sformatf("err_wait%0d", k), 160'({m0_pready, m1_pready}), 160'd0);
         next_cycle();
      end

      // Reset during ACCESS of an m1 transfer.
      m0_psel = 1'b0; out_pready = 1'b0; out_pslverr = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clock);
      check("rst_m1_access", 160'({out_psel, out_penable, out_paddr}), 160'({2'b11, A1}));
      out_pready = 1'b1;
      reset = 1'b1;
      #1;
      check("rst_immediate_zero", dut_vec(), 160'd0);
      next_cycle();
      @(negedge clock);
      check("rst_held_zero", dut_vec(), 160'd0);
      next_cycle();
      reset = 1'b0; m0_psel = 1'b1; m1_psel = 1'b1; out_pready = 1'b0;
      @(negedge clock);
      check("rst_release_idle", 160'(out_psel), 160'd0);
      next_cycle();
      @(negedge clock);
      check("rst_m0_first", 160'({out_psel, out_penable, out_paddr}), 160'({2'b10, A0}));
      next_cycle();

      // Random traffic against the model.
      reset = 1'b1; m0_psel = 1'b0; m1_psel = 1'b0;
      next_cycle();
      reset = 1'b0;
      m_act = 1'b0; m_last = 1'b1; m_own = 1'b0; m_age = 0;
      saw0 = 1'b0; saw1 = 1'b0;
      for (int cyc = 0; cyc < 2400; cyc++) begin
         if (!m0_psel) begin
            if ($urandom_range(0, 2) == 0) begin
               m0_psel = 1'b1; m0_penable = 1'b0; m0_paddr = $urandom; m0_pwdata = $urandom;
               m0_pwrite = 1'($urandom); m0_pstrb = 4'($urandom); m0_pprot = 3'($urandom);
            end
         end else if (saw0 || $urandom_range(0, 63) == 0) begin
            m0_psel = 1'b0; m0_penable = 1'b0;
         end else begin
            m0_penable = 1'b1;
         end
         if (!m1_psel) begin
            if ($urandom_range(0, 2) == 0) begin
               m1_psel = 1'b1; m1_penable = 1'b0; m1_paddr = $urandom; m1_pwdata = $urandom;
               m1_pwrite = 1'($urandom); m1_pstrb = 4'($urandom); m1_pprot = 3'($urandom);
            end
         end else if (saw1 || $urandom_range(0, 63) == 0) begin
            m1_psel = 1'b0; m1_penable = 1'b0;
         end else begin
            m1_penable = 1'b1;
         end
         rate = ((cyc / 400) % 2 == 1) ? 30 : 2;
         out_pready = ($urandom_range(0, rate) == 0);
         out_pslverr = ($urandom_range(0, 3) == 0);
         out_prdata = $urandom;
         @(negedge clock);
         exp = model_out(m_done);
         check($sformatf("random_cycle%0d", cyc), dut_vec(), exp);
         saw0 = exp[67];
         saw1 = exp[33];
         @(posedge clock);
         model_step();
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
